// File: rtl/i2s_pkg.sv
// Shared I2S constants: slot geometry, SDRAM region bases and FSM state encodings.
package i2s_pkg;

    localparam int unsigned SAMPLE_BITS = 16;
    localparam int unsigned SLOT_BITS   = 32;
    localparam int unsigned LANES       = 4;

    localparam logic [22:0] PLAY_BASE_ADDR    = 23'h000000;
    localparam logic [22:0] CAPTURE_BASE_ADDR = 23'h030000;

    localparam logic [1:0] CapStop     = 2'd0;
    localparam logic [1:0] CapWaitLeft = 2'd1;
    localparam logic [1:0] CapShift    = 2'd2;

    localparam logic WrIdle = 1'b0;
    localparam logic WrReq  = 1'b1;

endpackage

// File: rtl/i2s_word_fifo.sv
// Synchronous FIFO for packed capture words; push into a full FIFO is accepted only with a pop.
module i2s_word_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S capture: oversampled deserialiser packing L0,R0,L1,R1 into 64-bit words,
// buffered and written sequentially into an SDRAM region.
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter logic [22:0] BASE_ADDR  = CAPTURE_BASE_ADDR,
    parameter logic [22:0] NUM_WORDS  = 23'd65536,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        Clk50,
    input  logic        reset,
    input  logic        SClk,
    input  logic        LRClk,
    input  logic        Din,
    input  logic        enable,
    input  logic        sdram_Wait,
    input  logic        sdram_ac,
    output logic        sdram_wr,
    output logic [22:0] sdram_addr,
    output logic [63:0] sdram_wdata,
    output logic        busy,
    output logic        Capture_done,
    output logic        overflow,
    output logic [22:0] words_written
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0] sclk_sync_q;
    logic [1:0] lr_sync_q, din_sync_q;
    logic       sclk_rise, lr_s, din_s;

    logic [1:0]  cap_state_q, cap_state_d;
    logic        lr_prev_q, lr_prev_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [15:0] shift_q, shift_d;
    logic        committed_q, committed_d;
    logic [63:0] word_q, word_d;
    logic        push_q, push_d;
    logic        commit;
    logic [15:0] commit_val;
    logic [4:0]  pad;

    logic        wr_state_q, wr_state_d;
    logic [22:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [22:0] count_q, count_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [63:0]     fifo_rdata;
    logic [CntW-1:0] fifo_count;

    assign sclk_rise = (sclk_sync_q[2:1] == 2'b01);
    assign lr_s      = lr_sync_q[1];
    assign din_s     = din_sync_q[1];
    assign pad       = 5'(SAMPLE_BITS) - bitcnt_q;

    always_comb begin
        cap_state_d = cap_state_q;
        lr_prev_d   = lr_prev_q;
        lane_d      = lane_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        committed_d = committed_q;
        word_d      = word_q;
        push_d      = 1'b0;
        commit      = 1'b0;
        commit_val  = '0;

        if (sclk_rise) lr_prev_d = lr_s;

        case (cap_state_q)
            CapStop: begin
                if (enable && !done_q) cap_state_d = CapWaitLeft;
            end
            CapWaitLeft: begin
                if (!enable || done_q) begin
                    cap_state_d = CapStop;
                end else if (sclk_rise && lr_prev_q && !lr_s) begin
                    lane_d      = 2'd0;
                    bitcnt_d    = '0;
                    shift_d     = '0;
                    committed_d = 1'b0;
                    cap_state_d = CapShift;
                end
            end
            CapShift: begin
                if (!enable || done_q) begin
                    cap_state_d = CapStop;
                end else if (sclk_rise) begin
                    if (lr_s != lr_prev_q) begin
                        // Slot ended early: commit what we have, left-aligned.
                        if (!committed_q) begin
                            commit     = 1'b1;
                            commit_val = shift_q << pad;
                        end
                        lane_d      = lane_q + 2'd1;
                        bitcnt_d    = '0;
                        shift_d     = '0;
                        committed_d = 1'b0;
                    end else if (bitcnt_q < 5'(SAMPLE_BITS)) begin
                        shift_d  = {shift_q[14:0], din_s};
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'(SAMPLE_BITS - 1)) begin
                            commit      = 1'b1;
                            commit_val  = {shift_q[14:0], din_s};
                            committed_d = 1'b1;
                        end
                    end
                end
            end
            default: cap_state_d = CapStop;
        endcase

        if (commit) begin
            word_d[SAMPLE_BITS*lane_q +: 16] = commit_val;
            push_d = (lane_q == 2'(LANES - 1));
        end
    end

    assign fifo_push = push_q && !done_q;

    always_comb begin
        wr_state_d = wr_state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        done_d     = done_q;
        overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
        fifo_pop   = 1'b0;

        case (wr_state_q)
            WrIdle: begin
                if (fifo_count != '0 && !sdram_Wait && !done_q) begin
                    wdata_d    = fifo_rdata;
                    wr_state_d = WrReq;
                end
            end
            WrReq: begin
                if (sdram_ac) begin
                    fifo_pop   = !fifo_empty;
                    addr_d     = addr_q + 23'd1;
                    count_d    = count_q + 23'd1;
                    done_d     = (count_q + 23'd1 == NUM_WORDS);
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge Clk50) begin
        if (reset) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            cap_state_q <= CapStop;
            lr_prev_q   <= 1'b0;
            lane_q      <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            committed_q <= 1'b0;
            word_q      <= '0;
            push_q      <= 1'b0;
            wr_state_q  <= WrIdle;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SClk};
            lr_sync_q   <= {lr_sync_q[0], LRClk};
            din_sync_q  <= {din_sync_q[0], Din};
            cap_state_q <= cap_state_d;
            lr_prev_q   <= lr_prev_d;
            lane_q      <= lane_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            committed_q <= committed_d;
            word_q      <= word_d;
            push_q      <= push_d;
            wr_state_q  <= wr_state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    i2s_word_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (64)
    ) u_fifo (
        .clk_i   (Clk50),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (word_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign sdram_wr      = (wr_state_q == WrReq);
    assign busy          = (wr_state_q == WrReq);
    assign sdram_addr    = addr_q;
    assign sdram_wdata   = wdata_q;
    assign Capture_done  = done_q;
    assign overflow      = overflow_q;
    assign words_written = count_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Directed bench for i2s_rx_capture: drives I2S frames at SClk = Clk50/16 and checks SDRAM writes.
module tb_i2s_rx_capture;

    logic        Clk50, reset, SClk, LRClk, Din, enable, sdram_Wait;
    logic        sdram_ac, sdram_wr, busy, Capture_done, overflow;
    logic [22:0] sdram_addr, words_written;
    logic [63:0] sdram_wdata;
    logic        ac3, wr3, busy3, done3, ovf3;
    logic [22:0] addr3, ww3;
    logic [63:0] wdata3;

    int total = 0;
    int bad   = 0;
    logic        ack_en = 1'b0;
    logic [22:0] log_addr [64];
    logic [63:0] log_data [64];
    int          log_cnt = 0;
    logic [22:0] log3_addr [64];
    int          log3_cnt = 0;
    int          wr_after_done3 = 0;

    i2s_rx_capture dut (
        .Clk50 (Clk50), .reset (reset), .SClk (SClk), .LRClk (LRClk), .Din (Din),
        .enable (enable), .sdram_Wait (sdram_Wait), .sdram_ac (sdram_ac),
        .sdram_wr (sdram_wr), .sdram_addr (sdram_addr), .sdram_wdata (sdram_wdata),
        .busy (busy), .Capture_done (Capture_done), .overflow (overflow),
        .words_written (words_written)
    );

    i2s_rx_capture #(.NUM_WORDS (23'd3)) dut3 (
        .Clk50 (Clk50), .reset (reset), .SClk (SClk), .LRClk (LRClk), .Din (Din),
        .enable (enable), .sdram_Wait (sdram_Wait), .sdram_ac (ac3),
        .sdram_wr (wr3), .sdram_addr (addr3), .sdram_wdata (wdata3),
        .busy (busy3), .Capture_done (done3), .overflow (ovf3),
        .words_written (ww3)
    );

    initial begin
        Clk50 = 1'b0;
        forever #10 Clk50 = ~Clk50;
    end

    initial begin
        sdram_ac = 1'b0;
        ac3 = 1'b0;
    end

    // SDRAM models: log each request as it is acknowledged, ack is a one-cycle pulse.
    always @(negedge Clk50) begin
        if (sdram_ac) begin
            sdram_ac = 1'b0;
        end else if (sdram_wr && ack_en && log_cnt < 64) begin
            log_addr[log_cnt] = sdram_addr;
            log_data[log_cnt] = sdram_wdata;
            log_cnt++;
            sdram_ac = 1'b1;
        end
    end

    always @(negedge Clk50) begin
        if (done3 && wr3) wr_after_done3++;
        if (ac3) begin
            ac3 = 1'b0;
        end else if (wr3 && log3_cnt < 64) begin
            log3_addr[log3_cnt] = addr3;
            log3_cnt++;
            ac3 = 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge Clk50);
        reset = 1'b1;
        repeat (2) @(negedge Clk50);
        reset = 1'b0;
        @(negedge Clk50);
    endtask

    task automatic sclk_bit(input logic lr, input logic d);
        SClk  = 1'b0;
        LRClk = lr;
        Din   = d;
        repeat (8) @(negedge Clk50);
        SClk = 1'b1;
        repeat (8) @(negedge Clk50);
    endtask

    // Slot bit 0 is the one-bit delay; data MSB goes out in bit 1.
    task automatic send_bits(input logic lr, input logic [15:0] data, input int dbits,
                             input int from, input int upto);
        for (int b = from; b <= upto; b++) begin
            sclk_bit(lr, (b >= 1 && b <= dbits) ? data[16-b] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_bits(1'b0, l, 16, 0, 31);
        send_bits(1'b1, r, 16, 0, 31);
    endtask

    task automatic preamble();
        send_bits(1'b1, 16'h0000, 16, 0, 3);
    endtask

    task automatic wait_log(input int target, input int budget);
        int n = 0;
        while (log_cnt < target && n < budget) begin
            @(negedge Clk50);
            n++;
        end
        repeat (4) @(negedge Clk50);
    endtask

    task automatic test_reset();
        total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", sdram_wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (Capture_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", Capture_done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        total++; if (words_written !== 23'd0) begin bad++; $display("FAIL rst_ww: got %0d want 0", words_written); end
        total++; if (sdram_addr !== 23'h030000) begin bad++; $display("FAIL rst_addr: got %h want 030000", sdram_addr); end
        total++; if (sdram_wdata !== 64'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", sdram_wdata); end
    endtask

    task automatic test_stream();
        int base;
        do_reset();
        base = log_cnt;
        ack_en = 1'b1;
        sdram_Wait = 1'b1;
        enable = 1'b1;
        preamble();
        send_frame(16'hA5A5, 16'h3C3C);
        send_frame(16'hA5A5, 16'h3C3C);
        total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL stream_wait_blocks: wr=%b want 0", sdram_wr); end
        sdram_Wait = 1'b0;
        wait_log(base + 1, 200);
        total++; if (log_cnt !== base + 1) begin bad++; $display("FAIL stream_count: writes=%0d want 1", log_cnt - base); end
        total++; if (log_data[base] !== 64'h3C3CA5A53C3CA5A5) begin bad++; $display("FAIL stream_data: got %h want 3c3ca5a53c3ca5a5", log_data[base]); end
        total++; if (log_addr[base] !== 23'h030000) begin bad++; $display("FAIL stream_addr: got %h want 030000", log_addr[base]); end
        total++; if (words_written !== 23'd1) begin bad++; $display("FAIL stream_ww: got %0d want 1", words_written); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_busy: got %b want 0", busy); end
        total++; if (sdram_addr !== 23'h030001) begin bad++; $display("FAIL stream_next_addr: got %h want 030001", sdram_addr); end
    endtask

    task automatic test_enable_mid_slot();
        int base;
        enable = 1'b0;
        do_reset();
        base = log_cnt;
        send_bits(1'b0, 16'h1111, 16, 0, 31);
        send_bits(1'b1, 16'h2222, 16, 0, 9);
        enable = 1'b1;
        send_bits(1'b1, 16'h2222, 16, 10, 31);
        send_frame(16'h4444, 16'h5555);
        send_frame(16'h6666, 16'h7777);
        wait_log(base + 1, 200);
        total++; if (log_cnt !== base + 1) begin bad++; $display("FAIL midslot_count: writes=%0d want 1", log_cnt - base); end
        total++; if (log_data[base] !== 64'h7777666655554444) begin bad++; $display("FAIL midslot_data: got %h want 7777666655554444", log_data[base]); end
    endtask

    task automatic test_short_slot();
        int base;
        do_reset();
        base = log_cnt;
        preamble();
        send_bits(1'b0, 16'hFFF0, 12, 0, 12);
        send_bits(1'b1, 16'h3C3C, 16, 0, 31);
        send_frame(16'hA5A5, 16'h1234);
        wait_log(base + 1, 200);
        total++; if (log_cnt !== base + 1) begin bad++; $display("FAIL short_count: writes=%0d want 1", log_cnt - base); end
        total++; if (log_data[base] !== 64'h1234A5A53C3CFFF0) begin bad++; $display("FAIL short_data: got %h want 1234a5a53c3cfff0", log_data[base]); end
    endtask

    task automatic test_overflow();
        int base;
        logic [63:0] exp;
        ack_en = 1'b0;
        do_reset();
        base = log_cnt;
        preamble();
        for (int f = 0; f < 8; f++) send_frame(16'(16'h1000 + f), 16'(16'h2000 + f));
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_after4: got %b want 0", overflow); end
        total++; if (sdram_wr !== 1'b1) begin bad++; $display("FAIL ovf_wr_held: got %b want 1", sdram_wr); end
        for (int f = 8; f < 10; f++) send_frame(16'(16'h1000 + f), 16'(16'h2000 + f));
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after5: got %b want 1", overflow); end
        total++; if (words_written !== 23'd0) begin bad++; $display("FAIL ovf_ww_held: got %0d want 0", words_written); end
        ack_en = 1'b1;
        wait_log(base + 4, 200);
        repeat (40) @(negedge Clk50);
        total++; if (log_cnt !== base + 4) begin bad++; $display("FAIL ovf_count: writes=%0d want 4", log_cnt - base); end
        for (int w = 0; w < 4; w++) begin
            exp = {16'(16'h2000 + 2*w + 1), 16'(16'h1000 + 2*w + 1),
                   16'(16'h2000 + 2*w), 16'(16'h1000 + 2*w)};
            total++; if (log_data[base+w] !== exp) begin bad++; $display("FAIL ovf_data%0d: got %h want %h", w, log_data[base+w], exp); end
            total++; if (log_addr[base+w] !== 23'(23'h030000 + w)) begin bad++; $display("FAIL ovf_addr%0d: got %h want %h", w, log_addr[base+w], 23'(23'h030000 + w)); end
        end
        total++; if (words_written !== 23'd4) begin bad++; $display("FAIL ovf_ww: got %0d want 4", words_written); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid_write();
        int base;
        ack_en = 1'b0;
        do_reset();
        preamble();
        send_frame(16'hEEEE, 16'h1111);
        send_frame(16'h2222, 16'h3333);
        total++; if (sdram_wr !== 1'b1) begin bad++; $display("FAIL rmid_wr_before: got %b want 1", sdram_wr); end
        reset = 1'b1;
        @(negedge Clk50);
        reset = 1'b0;
        total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL rmid_wr: got %b want 0", sdram_wr); end
        total++; if (sdram_addr !== 23'h030000) begin bad++; $display("FAIL rmid_addr: got %h want 030000", sdram_addr); end
        total++; if (words_written !== 23'd0) begin bad++; $display("FAIL rmid_ww: got %0d want 0", words_written); end
        base = log_cnt;
        ack_en = 1'b1;
        repeat (40) @(negedge Clk50);
        total++; if (log_cnt !== base) begin bad++; $display("FAIL rmid_fifo_empty: writes=%0d want 0", log_cnt - base); end
        send_bits(1'b1, 16'h0000, 16, 20, 31);
        send_frame(16'hAAAA, 16'hBBBB);
        send_frame(16'hCCCC, 16'hDDDD);
        wait_log(base + 1, 200);
        total++; if (log_cnt !== base + 1) begin bad++; $display("FAIL rmid_count: writes=%0d want 1", log_cnt - base); end
        total++; if (log_data[base] !== 64'hDDDDCCCCBBBBAAAA) begin bad++; $display("FAIL rmid_data: got %h want ddddccccbbbbaaaa", log_data[base]); end
        total++; if (log_addr[base] !== 23'h030000) begin bad++; $display("FAIL rmid_addr2: got %h want 030000", log_addr[base]); end
    endtask

    task automatic test_capture_done();
        int base3, wad;
        do_reset();
        base3 = log3_cnt;
        wad = wr_after_done3;
        preamble();
        for (int f = 0; f < 8; f++) send_frame(16'(16'h5000 + f), 16'(16'h6000 + f));
        repeat (100) @(negedge Clk50);
        total++; if (log3_cnt !== base3 + 3) begin bad++; $display("FAIL done_count: writes=%0d want 3", log3_cnt - base3); end
        for (int w = 0; w < 3; w++) begin
            total++; if (log3_addr[base3+w] !== 23'(23'h030000 + w)) begin bad++; $display("FAIL done_addr%0d: got %h want %h", w, log3_addr[base3+w], 23'(23'h030000 + w)); end
        end
        total++; if (done3 !== 1'b1) begin bad++; $display("FAIL done_flag: got %b want 1", done3); end
        total++; if (ww3 !== 23'd3) begin bad++; $display("FAIL done_ww: got %0d want 3", ww3); end
        total++; if (wr_after_done3 !== wad) begin bad++; $display("FAIL done_wr_after: cycles=%0d want 0", wr_after_done3 - wad); end
        total++; if (Capture_done !== 1'b0) begin bad++; $display("FAIL done_main: got %b want 0", Capture_done); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        SClk = 1'b0;
        LRClk = 1'b0;
        Din = 1'b0;
        sdram_Wait = 1'b0;
        repeat (4) @(negedge Clk50);
        reset = 1'b0;
        @(negedge Clk50);
        test_reset();
        test_stream();
        test_enable_mid_slot();
        test_short_slot();
        test_overflow();
        test_reset_mid_write();
        test_capture_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
